// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: captures decoded RV32I instructions, derives alu_op,
// selects/bypasses ALU operands. Macro ID_EX_FWD_EN enables the EX/MEM and MEM/WB bypass network.
module id_ex_stage #(
    parameter int N_BITS     = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [N_BITS-1:0]     in_pc,
    input  logic [N_BITS-1:0]     in_rs1_data,
    input  logic [N_BITS-1:0]     in_rs2_data,
    input  logic [N_BITS-1:0]     in_imm,
    input  logic [REG_ADDR_W-1:0] in_rs1_addr,
    input  logic [REG_ADDR_W-1:0] in_rs2_addr,
    input  logic [REG_ADDR_W-1:0] in_rd_addr,
    input  logic [2:0]            in_funct3,
    input  logic                  in_funct7b5,
    input  logic [1:0]            in_op_kind,
    input  logic                  in_src0_sel,
    input  logic                  in_src1_sel,
    input  logic                  flush,
    input  logic                  exm_wen,
    input  logic [REG_ADDR_W-1:0] exm_rd,
    input  logic [N_BITS-1:0]     exm_data,
    input  logic                  exm_is_load,
    input  logic                  wb_wen,
    input  logic [REG_ADDR_W-1:0] wb_rd,
    input  logic [N_BITS-1:0]     wb_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [3:0]            alu_op,
    output logic [N_BITS-1:0]     alu_in0,
    output logic [N_BITS-1:0]     alu_in1,
    output logic [N_BITS-1:0]     out_rs2_val,
    output logic [REG_ADDR_W-1:0] out_rd_addr,
    output logic [N_BITS-1:0]     out_pc
);

    logic                  valid_q;
    logic [N_BITS-1:0]     pc_q, rs1_data_q, rs2_data_q, imm_q;
    logic [REG_ADDR_W-1:0] rs1_q, rs2_q, rd_q;
    logic [3:0]            alu_op_q;
    logic                  lui_q, src0_sel_q, src1_sel_q;

    logic                  stall, capture;
    logic                  exm_hit1, exm_hit2, wb_hit1, wb_hit2;
    logic [N_BITS-1:0]     fwd_rs1, fwd_rs2;
    logic [3:0]            alu_op_d;

    // Hits only consider non-zero sources, so x0 can never be bypassed or stalled on
    assign exm_hit1 = exm_wen && (rs1_q != '0) && (exm_rd == rs1_q);
    assign exm_hit2 = exm_wen && (rs2_q != '0) && (exm_rd == rs2_q);
    assign wb_hit1  = wb_wen  && (rs1_q != '0) && (wb_rd  == rs1_q);
    assign wb_hit2  = wb_wen  && (rs2_q != '0) && (wb_rd  == rs2_q);

`ifdef ID_EX_FWD_EN
    assign stall = valid_q && exm_is_load && (exm_hit1 || exm_hit2);

    always_comb begin
        fwd_rs1 = rs1_data_q;
        if (rs1_q == '0)                  fwd_rs1 = '0;
        else if (exm_hit1 && !exm_is_load) fwd_rs1 = exm_data;
        else if (wb_hit1)                 fwd_rs1 = wb_data;

        fwd_rs2 = rs2_data_q;
        if (rs2_q == '0)                  fwd_rs2 = '0;
        else if (exm_hit2 && !exm_is_load) fwd_rs2 = exm_data;
        else if (wb_hit2)                 fwd_rs2 = wb_data;
    end
`else
    assign stall = valid_q && (exm_hit1 || exm_hit2 || wb_hit1 || wb_hit2);

    always_comb begin
        fwd_rs1 = (rs1_q == '0) ? '0 : rs1_data_q;
        fwd_rs2 = (rs2_q == '0) ? '0 : rs2_data_q;
    end
`endif

    assign in_ready = !valid_q || (out_ready && !stall);
    assign capture  = in_valid && in_ready;
    assign out_valid = valid_q && !stall;

    always_comb begin
        alu_op_d = 4'b0000;
        if (in_op_kind == 2'b01 || in_op_kind == 2'b10) begin
            alu_op_d = {in_funct3, in_funct7b5 &&
                        ((in_funct3 == 3'b000 && in_op_kind == 2'b10) || in_funct3 == 3'b101)};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q    <= 1'b0;
            pc_q       <= '0;
            rs1_data_q <= '0;
            rs2_data_q <= '0;
            imm_q      <= '0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            rd_q       <= '0;
            alu_op_q   <= '0;
            lui_q      <= 1'b0;
            src0_sel_q <= 1'b0;
            src1_sel_q <= 1'b0;
        end else if (flush) begin
            valid_q <= 1'b0;
        end else if (capture) begin
            valid_q    <= 1'b1;
            pc_q       <= in_pc;
            rs1_data_q <= in_rs1_data;
            rs2_data_q <= in_rs2_data;
            imm_q      <= in_imm;
            rs1_q      <= in_rs1_addr;
            rs2_q      <= in_rs2_addr;
            rd_q       <= in_rd_addr;
            alu_op_q   <= alu_op_d;
            lui_q      <= (in_op_kind == 2'b11);
            src0_sel_q <= in_src0_sel;
            src1_sel_q <= in_src1_sel;
        end else if (out_ready && out_valid) begin
            valid_q <= 1'b0;
        end
    end

    assign alu_op      = alu_op_q;
    assign alu_in0     = lui_q ? '0 : (src0_sel_q ? pc_q : fwd_rs1);
    assign alu_in1     = src1_sel_q ? imm_q : fwd_rs2;
    assign out_rs2_val = fwd_rs2;
    assign out_rd_addr = rd_q;
    assign out_pc      = pc_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage with a scoreboard queue of expected ALU presentations.
// Expectations follow ID_EX_FWD_EN when the bench is compiled with that macro.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready;
    logic [31:0] in_pc, in_rs1_data, in_rs2_data, in_imm;
    logic [4:0]  in_rs1_addr, in_rs2_addr, in_rd_addr;
    logic [2:0]  in_funct3;
    logic        in_funct7b5;
    logic [1:0]  in_op_kind;
    logic        in_src0_sel, in_src1_sel, flush;
    logic        exm_wen, exm_is_load, wb_wen;
    logic [4:0]  exm_rd, wb_rd;
    logic [31:0] exm_data, wb_data;
    logic        out_valid, out_ready;
    logic [3:0]  alu_op;
    logic [31:0] alu_in0, alu_in1, out_rs2_val, out_pc;
    logic [4:0]  out_rd_addr;

`ifdef ID_EX_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    typedef struct {
        logic [3:0]  op;
        logic [31:0] in0, in1, rs2v, pc;
        logic [4:0]  rd;
    } exp_t;

    exp_t sb[$];
    int   n_asserts = 0;
    int   n_fail    = 0;

    id_ex_stage #(.N_BITS(32), .REG_ADDR_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data), .in_imm(in_imm),
        .in_rs1_addr(in_rs1_addr), .in_rs2_addr(in_rs2_addr), .in_rd_addr(in_rd_addr),
        .in_funct3(in_funct3), .in_funct7b5(in_funct7b5), .in_op_kind(in_op_kind),
        .in_src0_sel(in_src0_sel), .in_src1_sel(in_src1_sel), .flush(flush),
        .exm_wen(exm_wen), .exm_rd(exm_rd), .exm_data(exm_data), .exm_is_load(exm_is_load),
        .wb_wen(wb_wen), .wb_rd(wb_rd), .wb_data(wb_data),
        .out_valid(out_valid), .out_ready(out_ready), .alu_op(alu_op),
        .alu_in0(alu_in0), .alu_in1(alu_in1), .out_rs2_val(out_rs2_val),
        .out_rd_addr(out_rd_addr), .out_pc(out_pc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_in(input logic [31:0] pc, input logic [4:0] rs1a, input logic [31:0] rs1d,
                          input logic [4:0] rs2a, input logic [31:0] rs2d, input logic [31:0] imm,
                          input logic [4:0] rd, input logic [2:0] f3, input logic f7,
                          input logic [1:0] kind, input logic s0, input logic s1);
        in_pc = pc; in_rs1_addr = rs1a; in_rs1_data = rs1d; in_rs2_addr = rs2a;
        in_rs2_data = rs2d; in_imm = imm; in_rd_addr = rd; in_funct3 = f3;
        in_funct7b5 = f7; in_op_kind = kind; in_src0_sel = s0; in_src1_sel = s1;
    endtask

    // Called at a negedge; holds in_valid until one capture edge has passed.
    task automatic send(input string tag, input logic [31:0] pc, input logic [4:0] rs1a,
                        input logic [31:0] rs1d, input logic [4:0] rs2a, input logic [31:0] rs2d,
                        input logic [31:0] imm, input logic [4:0] rd, input logic [2:0] f3,
                        input logic f7, input logic [1:0] kind, input logic s0, input logic s1);
        int n = 0;
        set_in(pc, rs1a, rs1d, rs2a, rs2d, imm, rd, f3, f7, kind, s0, s1);
        in_valid = 1'b1;
        #1;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_accept"}, {31'b0, in_ready}, 32'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic push(input logic [3:0] op, input logic [31:0] in0, input logic [31:0] in1,
                        input logic [31:0] rs2v, input logic [4:0] rd, input logic [31:0] pc);
        exp_t e;
        e.op = op; e.in0 = in0; e.in1 = in1; e.rs2v = rs2v; e.rd = rd; e.pc = pc;
        sb.push_back(e);
    endtask

    task automatic drain_now(input string tag);
        int   n = 0;
        exp_t e;
        #1;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_valid"}, {31'b0, out_valid}, 32'd1);
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            chk({tag, "_op"},  {28'b0, alu_op}, {28'b0, e.op});
            chk({tag, "_in0"}, alu_in0, e.in0);
            chk({tag, "_in1"}, alu_in1, e.in1);
            chk({tag, "_rs2"}, out_rs2_val, e.rs2v);
            chk({tag, "_rd"},  {27'b0, out_rd_addr}, {27'b0, e.rd});
            chk({tag, "_pc"},  out_pc, e.pc);
        end
    endtask

    task automatic drain(input string tag);
        @(negedge clk);
        drain_now(tag);
    endtask

    // op_kind, funct3, funct7b5, expected alu_op
    logic [1:0] t_kind[11] = '{2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd1, 2'd0, 2'd2, 2'd2, 2'd2, 2'd2};
    logic [2:0] t_f3[11]   = '{3'd0, 3'd5, 3'd5, 3'd7, 3'd2, 3'd1, 3'd5, 3'd0, 3'd6, 3'd4, 3'd3};
    logic       t_f7[11]   = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [3:0] t_op[11]   = '{4'h0, 4'hB, 4'hA, 4'hE, 4'h4, 4'h2, 4'h0, 4'h0, 4'hC, 4'h8, 4'h6};

    initial begin
        logic [31:0] d0;
        rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        set_in('0, '0, '0, '0, '0, '0, '0, '0, 1'b0, '0, 1'b0, 1'b0);
        exm_wen = 1'b0; exm_rd = '0; exm_data = '0; exm_is_load = 1'b0;
        wb_wen = 1'b0; wb_rd = '0; wb_data = '0;

        repeat (2) @(negedge clk);
        chk("rst_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_op", {28'b0, alu_op}, 32'd0);
        chk("rst_in0", alu_in0, 32'd0);
        chk("rst_in1", alu_in1, 32'd0);
        chk("rst_pc", out_pc, 32'd0);
        chk("rst_ready", {31'b0, in_ready}, 32'd1);
        rst_n = 1'b1;

        @(negedge clk);
        push(4'h1, 32'd10, 32'd3, 32'd3, 5'd4, 32'h100);
        send("sub", 32'h100, 5'd1, 32'd10, 5'd2, 32'd3, 32'h55, 5'd4, 3'd0, 1'b1, 2'd2, 1'b0, 1'b0);
        drain("sub");

        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            push(t_op[i], 32'h1000 + i, (t_kind[i] == 2'd1) ? 32'd4 : 32'h2000 + i,
                 32'h2000 + i, 5'(i + 1), 32'h200 + 4 * i);
            send("op", 32'h200 + 4 * i, 5'd1, 32'h1000 + i, 5'd2, 32'h2000 + i, 32'd4, 5'(i + 1),
                 t_f3[i], t_f7[i], t_kind[i], 1'b0, t_kind[i] == 2'd1);
            drain("op");
        end

        @(negedge clk);
        push(4'h0, 32'd0, 32'h12345000, 32'd0, 5'd9, 32'h280);
        send("lui", 32'h280, 5'd3, 32'h999, 5'd0, 32'd0, 32'h12345000, 5'd9, 3'd5, 1'b1, 2'd3, 1'b0, 1'b1);
        drain("lui");

        @(negedge clk);
        push(4'h0, 32'h300, 32'h1000, 32'd0, 5'd10, 32'h300);
        send("auipc", 32'h300, 5'd1, 32'h5, 5'd0, 32'd0, 32'h1000, 5'd10, 3'd0, 1'b0, 2'd0, 1'b1, 1'b1);
        drain("auipc");

        @(negedge clk);
        exm_wen = 1'b1; exm_rd = 5'd5; exm_data = 32'hAA; exm_is_load = 1'b0;
        wb_wen = 1'b1; wb_rd = 5'd5; wb_data = 32'hBB;
        push(4'h0, FWD ? 32'hAA : 32'h11, 32'd8, FWD ? 32'hAA : 32'h22, 5'd6, 32'h400);
        send("fwd", 32'h400, 5'd5, 32'h11, 5'd5, 32'h22, 32'd8, 5'd6, 3'd0, 1'b0, 2'd1, 1'b0, 1'b1);
        if (!FWD) begin
            @(negedge clk);
            chk("nofwd_stall_valid", {31'b0, out_valid}, 32'd0);
            chk("nofwd_stall_ready", {31'b0, in_ready}, 32'd0);
            exm_wen = 1'b0; wb_wen = 1'b0;
            drain_now("fwd");
        end else begin
            drain("fwd");
        end
        exm_wen = 1'b0; wb_wen = 1'b0;

        @(negedge clk);
        exm_wen = 1'b1; exm_rd = 5'd0; exm_data = 32'hCC;
        wb_wen = 1'b1; wb_rd = 5'd0; wb_data = 32'hDD;
        d0 = FWD ? 32'h77 : 32'h0;
        push(4'h0, 32'd0, 32'd0, 32'd0, 5'd11, 32'h480);
        send("x0", 32'h480, 5'd0, d0, 5'd0, d0, 32'd0, 5'd11, 3'd0, 1'b0, 2'd2, 1'b0, 1'b0);
        drain("x0");
        exm_wen = 1'b0; wb_wen = 1'b0;

        @(negedge clk);
        exm_wen = 1'b1; exm_rd = 5'd7; exm_data = 32'h99; exm_is_load = 1'b1;
        push(4'h0, 32'h30, FWD ? 32'h55 : 32'h22, FWD ? 32'h55 : 32'h22, 5'd8, 32'h500);
        send("ldu", 32'h500, 5'd1, 32'h30, 5'd7, 32'h22, 32'd0, 5'd8, 3'd0, 1'b0, 2'd2, 1'b0, 1'b0);
        @(negedge clk);
        chk("ldu_stall_valid", {31'b0, out_valid}, 32'd0);
        chk("ldu_stall_ready", {31'b0, in_ready}, 32'd0);
        exm_is_load = 1'b0; exm_wen = 1'b0;
        wb_wen = 1'b1; wb_rd = 5'd7; wb_data = 32'h55;
        if (!FWD) begin
            @(negedge clk);
            chk("nofwd_wb_stall", {31'b0, out_valid}, 32'd0);
            wb_wen = 1'b0;
        end
        drain_now("ldu");
        wb_wen = 1'b0;

        @(negedge clk);
        flush = 1'b1;
        #1 chk("flush_ready", {31'b0, in_ready}, 32'd1);
        send("flush", 32'h600, 5'd1, 32'h1, 5'd2, 32'h2, 32'd0, 5'd3, 3'd0, 1'b0, 2'd2, 1'b0, 1'b0);
        flush = 1'b0;
        @(negedge clk);
        chk("flush_valid", {31'b0, out_valid}, 32'd0);

        @(negedge clk);
        out_ready = 1'b0;
        push(4'h8, 32'h61, 32'h62, 32'h62, 5'd12, 32'h640);
        send("hold", 32'h640, 5'd1, 32'h61, 5'd2, 32'h62, 32'd0, 5'd12, 3'd4, 1'b0, 2'd2, 1'b0, 1'b0);
        @(negedge clk);
        chk("hold_valid", {31'b0, out_valid}, 32'd1);
        chk("hold_ready", {31'b0, in_ready}, 32'd0);
        set_in(32'h680, 5'd3, 32'h71, 5'd4, 32'h72, 32'd0, 5'd13, 3'd0, 1'b1, 2'd2, 1'b0, 1'b0);
        in_valid = 1'b1;
        @(negedge clk);
        chk("hold2_ready", {31'b0, in_ready}, 32'd0);
        chk("hold2_in0", alu_in0, sb[0].in0);
        chk("hold2_pc", out_pc, sb[0].pc);
        out_ready = 1'b1;
        drain_now("hold");
        push(4'h1, 32'h71, 32'h72, 32'h72, 5'd13, 32'h680);
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        chk("nobubble_valid", {31'b0, out_valid}, 32'd1);
        drain_now("replace");

        @(negedge clk);
        out_ready = 1'b0;
        send("arst", 32'h700, 5'd1, 32'h5, 5'd2, 32'h6, 32'd0, 5'd14, 3'd0, 1'b1, 2'd2, 1'b0, 1'b0);
        @(negedge clk);
        chk("arst_pre_valid", {31'b0, out_valid}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", {31'b0, out_valid}, 32'd0);
        chk("arst_op", {28'b0, alu_op}, 32'd0);
        chk("arst_pc", out_pc, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("post_rst_valid", {31'b0, out_valid}, 32'd0);
        chk("sb_drained", sb.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register feeding the RV32I ALU.
- Captures decoded instructions from the decode stage under a valid/ready handshake and derives the 4-bit alu_op.
- Selects and forwards ALU operands, then presents alu_op/alu_in0/alu_in1 to the ALU in the execute stage.
- Handles EX/MEM and MEM/WB bypass, load-use bubbles and branch flush.

Parameters:
- N_BITS, 32, datapath width.
- REG_ADDR_W, 5, register-index width.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  decode has an instruction
- in_ready  out  1  stage can accept
- in_pc  in  N_BITS  instruction PC
- in_rs1_data  in  N_BITS  regfile read 1
- in_rs2_data  in  N_BITS  regfile read 2
- in_imm  in  N_BITS  sign-extended immediate
- in_rs1_addr  in  REG_ADDR_W  source 1 index
- in_rs2_addr  in  REG_ADDR_W  source 2 index
- in_rd_addr  in  REG_ADDR_W  destination index
- in_funct3  in  3  instruction funct3
- in_funct7b5  in  1  instruction bit 30
- in_op_kind  in  2  00 force-ADD (load/store/AUIPC/JAL/JALR), 01 I-arith, 10 R-type, 11 LUI
- in_src0_sel  in  1  0 rs1, 1 pc
- in_src1_sel  in  1  0 rs2, 1 imm
- flush  in  1  kill the held instruction
- exm_wen  in  1  EX/MEM writes rd
- exm_rd  in  REG_ADDR_W  EX/MEM destination
- exm_data  in  N_BITS  EX/MEM result
- exm_is_load  in  1  EX/MEM instruction is a load
- wb_wen  in  1  MEM/WB writes rd
- wb_rd  in  REG_ADDR_W  MEM/WB destination
- wb_data  in  N_BITS  MEM/WB result
- out_valid  out  1  ALU inputs valid
- out_ready  in  1  execute consumes
- alu_op  out  4  ALU operation
- alu_in0  out  N_BITS  ALU operand 0
- alu_in1  out  N_BITS  ALU operand 1
- out_rs2_val  out  N_BITS  forwarded rs2 (store data)
- out_rd_addr  out  REG_ADDR_W  registered rd
- out_pc  out  N_BITS  registered pc

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous, active-low, on rst_n.
- Reset values: valid_q = 0 and all registered fields = 0. Therefore out_valid = 0, alu_op = 0000, and all data outputs = 0.
- Acceptance: in_ready = !valid_q | (out_ready & !stall). Capture occurs on in_valid & in_ready. Latency is 1 cycle from capture to out_valid.
- Stall: stall = valid_q & exm_is_load & exm_wen & exm_rd != 0 & (exm_rd == rs1_q | exm_rd == rs2_q).
- out_valid = valid_q & !stall. During a stall, registered contents are held.
- Valid update: if out_ready & out_valid and there is no new capture, valid_q clears to 0.
- Flush:
  - Synchronous; takes priority over capture.
  - Next cycle valid_q = 0; the incoming instruction in the same cycle is dropped.
  - in_ready is unaffected.
- alu_op encoding: ADD 0000, SUB 0001, SLL 0010, SLT 0100, SLTU 0110, XOR 1000, SRL 1010, SRA 1011, OR 1100, AND 1110.
- alu_op is computed at capture and registered:
  - op_kind 00 or 11: alu_op = 0000.
  - Otherwise: alu_op = {funct3, b0}, where b0 = funct7b5 & ((funct3 == 000 & op_kind == 10) | funct3 == 101).
- Forwarding (combinational from registers; applies to rs1 and rs2 independently):
  - Source index 0: value is always 0, never forwarded.
  - Else if exm_wen & exm_rd == rs and not a load: use exm_data.
  - Else if wb_wen & wb_rd == rs: use wb_data.
  - Else: use the registered regfile value.
- Forwarding priority: EX/MEM over MEM/WB.
- Operand muxing:
  - alu_in0 = 0 for LUI; else pc_q if src0_sel; else fwd_rs1.
  - alu_in1 = imm_q if src1_sel; else fwd_rs2.
  - out_rs2_val = fwd_rs2 regardless of src1_sel.
- Simultaneous accept and drain in the same cycle: the stage is replaced with no bubble.

Optional Feature:
- Macro: ID_EX_FWD_EN.
- Defined: bypass network as described above.
- Undefined:
  - No bypass muxes; operands come from registered regfile values only.
  - stall extends to any exm_wen or wb_wen match on a non-zero rs1_q/rs2_q, not only loads.
  - out_valid stays low until the hazard clears.

Test Plan:
- Reset mid-operation with valid_q = 1: assert rst_n = 0 asynchronously -> out_valid = 0 immediately and alu_op = 0000.
- R-type SUB (funct3 000, f7b5 1, op_kind 10), rs1 = 10, rs2 = 3 -> next cycle out_valid = 1, alu_op = 0001, in0 = 10, in1 = 3. I-type funct3 000 with f7b5 1 -> alu_op = 0000.
- SRAI (op_kind 01, funct3 101, f7b5 1, imm = 4) -> alu_op = 1011, alu_in1 = 4. LUI with imm = 0x12345000 -> alu_in0 = 0, alu_in1 = 0x12345000.
- rs1 = x5 with exm_wen, exm_rd = 5, exm_data = 0xAA, and wb_rd = 5, wb_data = 0xBB -> alu_in0 = 0xAA. With rs1 = x0 and exm_rd = 0 -> alu_in0 = 0.
- Load-use: exm_is_load, exm_rd = 7, rs2_q = 7 -> out_valid = 0 and in_ready = 0 for that cycle. When exm_is_load drops and wb_rd = 7, wb_data = 0x55 -> out_valid = 1, alu_in1 = 0x55.
- flush asserted together with in_valid & in_ready -> next cycle out_valid = 0. out_ready held low with a held instruction -> outputs are stable and in_ready = 0.
